l2_write_buffer: RTL and testbench
==================================

L2_WRITE_BUFFER -- requirements
Module: l2_write_buffer

Interface
REQ-001 Parameters SHALL be: WB_DEPTH, 4, number of writeback entries (power of two, 2..16).
REQ-002 The module SHALL have one clock and a synchronous, active-high reset.
REQ-003 Port clk_i, input, 1 bit: clock; all state updates on its rising edge.
REQ-004 Port rst_i, input, 1 bit: synchronous active-high reset.
REQ-005 Port l2_req_i, input, mem_req_type: L2 request (addr[31:0], data[127:0], rw 1=write, valid).
REQ-006 Port l2_res_o, output, mem_data_type: response to L2 (data[127:0], ready).
REQ-007 Port mem_req_o, output, mem_req_type: request to main memory.
REQ-008 Port mem_res_i, input, mem_data_type: main-memory response.
REQ-009 Port occupancy_o, output, $clog2(WB_DEPTH)+1 bits: valid entry count.

Function
REQ-010 Handshake: requester holds valid and payload stable until ready is high for one cycle; ready is a single-cycle pulse; this applies on both ports.
REQ-011 Line address SHALL be addr[31:4]; addr[3:0] is ignored for matching and forced to 0 on mem_req_o.
REQ-012 Storage: circular FIFO of WB_DEPTH entries {line addr, 128-bit data}, with head/tail pointers that wrap modulo WB_DEPTH.
REQ-013 L2 write, buffer not full: the entry is pushed at the tail and l2_res_o.ready is asserted the cycle after valid is sampled.
REQ-014 L2 write, buffer full: ready stays low until a drain pop frees an entry; the push occurs the cycle after the pop.
REQ-015 L2 write whose line already has an entry: the youngest matching entry is overwritten in place with no new push; a full buffer accepts it.
REQ-016 L2 read hitting a buffered line: the youngest match's data is returned with ready one cycle after valid; no memory access occurs.
REQ-017 L2 read missing the buffer: it is issued to memory as rw=0, and mem_res_i.data is passed to l2_res_o with ready in the cycle after mem_res_i.ready.
REQ-018 FSM states SHALL be IDLE, RD_MEM and WR_MEM.
REQ-019 IDLE to RD_MEM on a pending missing read; IDLE to WR_MEM when no read is pending and occupancy is above 0.
REQ-020 A read has priority over a drain, except when the buffer is full and an L2 write is waiting; then the drain goes first.
REQ-021 WR_MEM presents the head entry (rw=1, valid=1); on mem_res_i.ready the head is popped and the FSM returns to IDLE.
REQ-022 RD_MEM holds the read request until mem_res_i.ready, then returns to IDLE.
REQ-023 mem_req_o.valid SHALL be registered and held until ready; an in-flight memory transaction is never abandoned or reordered.
REQ-024 A simultaneous push (L2 write) and pop (drain complete) in one cycle leaves occupancy unchanged.
REQ-025 Forwarding/merge compares against entries as they stood at the start of the cycle; the entry being popped that cycle still counts as a match.

Reset
REQ-026 On rst_i: pointers=0, occupancy_o=0, FSM=IDLE, mem_req_o all fields 0, l2_res_o all fields 0.
REQ-027 Reset mid-transaction: buffered writes are discarded; the bench SHALL NOT rely on completion of in-flight memory transactions.

Configuration
REQ-028 Macro WB_FWD_EN. When defined, REQ-016 forwarding and REQ-015 merge are compiled in.
REQ-029 Without WB_FWD_EN: every L2 read waits until occupancy is 0, then goes to memory (RD_MEM); every write pushes a new entry; there are no address comparators.

Structure
REQ-030 mem_req_type and mem_data_type are taken from cache_def.
REQ-031 WB_DEPTH_DEFAULT and the entry struct wb_entry_type SHALL be added to cache_def.
REQ-032 One sub-module, wb_fifo (storage, pointers, occupancy), SHALL be used; the FSM, match logic and muxing stay in l2_write_buffer.

Verification
REQ-033 Write A=0x0000_1000, D=0x11..11 -> ready the next cycle, occupancy 1 -> drain: mem_req_o {0x1000, rw=1} held until mem ready, then occupancy 0.
REQ-034 Memory stalled; five writes to distinct lines (WB_DEPTH=4) -> first four acked; fifth ready low until the first pop, then acked; memory sees the writes in FIFO order.
REQ-035 (WB_FWD_EN) Buffer write 0x2000 with D1, then read 0x2004 -> D1 returned one cycle later; no mem_req_o.valid with rw=0.
REQ-036 (WB_FWD_EN) Write 0x3000 D1, then write 0x3000 D2 -> occupancy stays 1; the drain writes D2.
REQ-037 Without WB_FWD_EN: occupancy 2, then read 0x4000 -> both drains complete before mem_req_o shows the rw=0 read; data matches the memory model.
REQ-038 rst_i asserted during WR_MEM -> the next cycle has occupancy 0, mem_req_o.valid 0, FSM IDLE.

Source files
------------

// File: rtl/cache_def.sv
// Shared cache/memory bus types plus the write-buffer entry format and default depth.
package cache_def;

  localparam int WB_DEPTH_DEFAULT = 4;
  localparam int LINE_W           = 28;

  typedef struct packed {
    logic [31:0]  addr;
    logic [127:0] data;
    logic         rw;     // 1 = write
    logic         valid;
  } mem_req_type;

  typedef struct packed {
    logic [127:0] data;
    logic         ready;
  } mem_data_type;

  typedef struct packed {
    logic [LINE_W-1:0] line;
    logic [127:0]      data;
  } wb_entry_type;

  typedef enum logic [1:0] {IDLE, RD_MEM, WR_MEM} wb_state_e;

  function automatic logic [LINE_W-1:0] line_of(input logic [31:0] addr);
    return addr[31:4];
  endfunction

endpackage

// File: rtl/l2_write_buffer_if.sv
// Bundle of the L2-side and memory-side request/response structs of the write buffer.
interface l2_write_buffer_if;
  import cache_def::*;

  mem_req_type  l2_req;
  mem_data_type l2_res;
  mem_req_type  mem_req;
  mem_data_type mem_res;

  // master: the L2 requester plus main memory; slave: the write buffer
  modport master (output l2_req, output mem_res, input l2_res, input mem_req);
  modport slave  (input l2_req, input mem_res, output l2_res, output mem_req);
endinterface

// File: rtl/wb_fifo.sv
// Circular entry store for the write buffer: head/tail pointers, occupancy count.
// With WB_FWD_EN the store also exposes every slot and supports in-place data overwrite.
module wb_fifo
  import cache_def::*;
#(
  parameter int DEPTH = WB_DEPTH_DEFAULT,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               push,
  input  wb_entry_type       push_entry,
  input  logic               pop,
`ifdef WB_FWD_EN
  input  logic               wr_en,
  input  logic [PTR_W-1:0]   wr_idx,
  input  logic [127:0]       wr_data,
  output wb_entry_type       entries [DEPTH],
  output logic [PTR_W-1:0]   head_ptr,
`endif
  output wb_entry_type       head_entry,
  output logic [CNT_W-1:0]   count
);

  wb_entry_type     store [DEPTH];
  logic [PTR_W-1:0] head_q;
  logic [PTR_W-1:0] tail_q;

  // NOTE: the storage array is deliberately not reset; slot validity comes from head/count alone.
  always_ff @(posedge clk_i) begin
    if (push) store[tail_q] <= push_entry;
`ifdef WB_FWD_EN
    if (wr_en) store[wr_idx].data <= wr_data;
`endif
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      head_q <= '0;
      tail_q <= '0;
      count  <= '0;
    end else begin
      if (push) tail_q <= tail_q + PTR_W'(1);
      if (pop)  head_q <= head_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  assign head_entry = store[head_q];
`ifdef WB_FWD_EN
  assign entries  = store;
  assign head_ptr = head_q;
`endif

endmodule

// File: rtl/l2_write_buffer.sv
// L2 write buffer: queues L2 line writes and drains them to main memory, passing reads through.
// Define WB_FWD_EN to compile in read forwarding and write merging against buffered lines.
module l2_write_buffer
  import cache_def::*;
#(
  parameter int WB_DEPTH = WB_DEPTH_DEFAULT
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  mem_req_type               l2_req_i,
  output mem_data_type              l2_res_o,
  output mem_req_type               mem_req_o,
  input  mem_data_type              mem_res_i,
  output logic [$clog2(WB_DEPTH):0] occupancy_o
);

  localparam int PTR_W = $clog2(WB_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  wb_state_e        state;
  wb_entry_type     head_entry;
  wb_entry_type     push_entry;
  logic [CNT_W-1:0] count;
  logic             full;
  logic             l2_wr, l2_rd;
  logic             push, pop, wr_ack;
  logic             rd_issue, drain_issue;
  logic             unused_addr_bits;

  assign full       = (count == CNT_W'(WB_DEPTH));
  assign push_entry = '{line: line_of(l2_req_i.addr), data: l2_req_i.data};
  assign unused_addr_bits = ^l2_req_i.addr[3:0];

  // A request is new only while no response pulse for it is out; RD_MEM owns the L2 port.
  assign l2_wr = l2_req_i.valid &&  l2_req_i.rw && !l2_res_o.ready;
  assign l2_rd = l2_req_i.valid && !l2_req_i.rw && !l2_res_o.ready && (state != RD_MEM);
  assign pop   = (state == WR_MEM) && mem_res_i.ready;

`ifdef WB_FWD_EN
  wb_entry_type     entries [WB_DEPTH];
  logic [PTR_W-1:0] head_ptr;
  logic [PTR_W-1:0] hit_idx;
  logic             hit, merge, rd_hit;

  // Oldest-to-youngest scan over pre-edge entries, so the last match is the youngest.
  // NOTE: every always_comb output gets a default first so no latch can be inferred.
  always_comb begin
    logic [PTR_W-1:0] idx;
    hit     = 1'b0;
    hit_idx = head_ptr;
    idx     = head_ptr;
    for (int age = 0; age < WB_DEPTH; age++) begin
      idx = head_ptr + PTR_W'(age);
      if ((CNT_W'(age) < count) && (entries[idx].line == line_of(l2_req_i.addr))) begin
        hit     = 1'b1;
        hit_idx = idx;
      end
    end
  end

  assign merge    = l2_wr && hit;
  assign push     = l2_wr && !hit && !full;
  assign rd_hit   = l2_rd && hit;
  assign rd_issue = l2_rd && !hit && (state == IDLE);
  assign wr_ack   = push || merge;
`else
  assign push     = l2_wr && !full;
  assign rd_issue = l2_rd && (state == IDLE) && (count == '0);
  assign wr_ack   = push;
`endif

  // A full buffer with a waiting write never has a read on the port, so reads simply win here.
  assign drain_issue = (state == IDLE) && !rd_issue && (count != '0);

  wb_fifo #(.DEPTH(WB_DEPTH)) u_fifo (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
`ifdef WB_FWD_EN
    .wr_en      (merge),
    .wr_idx     (hit_idx),
    .wr_data    (l2_req_i.data),
    .entries    (entries),
    .head_ptr   (head_ptr),
`endif
    .head_entry (head_entry),
    .count      (count)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= IDLE;
      mem_req_o <= '0;
      l2_res_o  <= '0;
    end else begin
      l2_res_o.ready <= wr_ack;
`ifdef WB_FWD_EN
      if (rd_hit) begin
        l2_res_o.data  <= entries[hit_idx].data;
        l2_res_o.ready <= 1'b1;
      end
`endif
      case (state)
        IDLE: begin
          if (rd_issue) begin
            mem_req_o <= '{addr: {line_of(l2_req_i.addr), 4'h0}, data: '0, rw: 1'b0, valid: 1'b1};
            state     <= RD_MEM;
          end else if (drain_issue) begin
            mem_req_o <= '{addr: {head_entry.line, 4'h0}, data: head_entry.data, rw: 1'b1, valid: 1'b1};
            state     <= WR_MEM;
          end
        end
        RD_MEM: begin
          if (mem_res_i.ready) begin
            l2_res_o.data  <= mem_res_i.data;
            l2_res_o.ready <= 1'b1;
            mem_req_o      <= '0;
            state          <= IDLE;
          end
        end
        WR_MEM: begin
          if (mem_res_i.ready) begin
            mem_req_o <= '0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign occupancy_o = count;

endmodule

// File: tb/tb_l2_write_buffer.sv
// Self-checking bench for l2_write_buffer: directed vectors, corner sequences, randomized traffic
// against a line-level memory model ("a read returns the latest write to that line").
module tb_l2_write_buffer;
  import cache_def::*;

  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst;
  logic [$clog2(DEPTH):0] occ;

  l2_write_buffer_if bus ();

  l2_write_buffer #(.WB_DEPTH(DEPTH)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .l2_req_i    (bus.l2_req),
    .l2_res_o    (bus.l2_res),
    .mem_req_o   (bus.mem_req),
    .mem_res_i   (bus.mem_res),
    .occupancy_o (occ)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0]  addr;
    logic [127:0] data;
    bit           rw;
    int           exp_lat;
    int           exp_occ;
  } vec_t;

  typedef struct {
    logic [31:0]  addr;
    logic [127:0] data;
    bit           rw;
  } log_t;

  int   n_checks = 0;
  int   n_err    = 0;
  log_t mem_log[$];
  logic [127:0] mem_store [logic [27:0]];
  bit   mem_stall;
  int   lat_max;

  function automatic logic [127:0] def_data(input logic [27:0] line);
    return {4{4'hA, line}};
  endfunction

  task automatic check(input string name, input logic [191:0] act, input logic [191:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Main-memory model: responds to a held request with a one-cycle ready pulse.
  initial begin
    logic [27:0] line;
    bus.mem_res = '0;
    forever begin
      tick();
      if (bus.mem_res.ready || rst) begin
        bus.mem_res = '0;
      end else if (bus.mem_req.valid && !mem_stall && $urandom_range(0, lat_max) == 0) begin
        line = bus.mem_req.addr[31:4];
        if (bus.mem_req.rw) begin
          mem_store[line]  = bus.mem_req.data;
          bus.mem_res.data = '0;
        end else begin
          bus.mem_res.data = mem_store.exists(line) ? mem_store[line] : def_data(line);
        end
        mem_log.push_back('{bus.mem_req.addr, bus.mem_req.data, bus.mem_req.rw});
        bus.mem_res.ready = 1'b1;
      end
    end
  end

  task automatic l2_xact(input logic [31:0] addr, input logic [127:0] data, input bit rw,
                         output logic [127:0] rdata, output int lat);
    bus.l2_req = '{addr: addr, data: data, rw: rw, valid: 1'b1};
    lat = 0;
    do begin
      tick();
      lat++;
    end while (!bus.l2_res.ready && lat < 500);
    rdata = bus.l2_res.data;
    check("l2_ready_seen", bus.l2_res.ready, 1'b1);
    bus.l2_req = '0;
    tick();
  endtask

  task automatic wait_occ_zero(input string name);
    int n = 0;
    while (occ != 0 && n < 1000) begin
      tick();
      n++;
    end
    check(name, occ, 0);
  endtask

  task automatic wait_mem_valid(input string name);
    int n = 0;
    while (!bus.mem_req.valid && n < 100) begin
      tick();
      n++;
    end
    check(name, bus.mem_req.valid, 1'b1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vec_t         vecs [4];
    logic [127:0] rd;
    logic [127:0] d1, d2;
    int           lat;
    int           n;
    logic [127:0] ref_mem [logic [27:0]];

    for (int i = 0; i < 4; i++) begin
      vecs[i].addr    = 32'h0000_5000 + 32'(i * 16) + ((i == 1) ? 32'h4 : 32'h0);
      vecs[i].data    = {4{32'hC0DE_0000 + 32'(i)}};
      vecs[i].rw      = 1'b1;
      vecs[i].exp_lat = 1;
      vecs[i].exp_occ = i + 1;
    end

    bus.l2_req = '0;
    rst        = 1'b1;
    mem_stall  = 1'b1;
    lat_max    = 0;
    repeat (3) tick();
    check("reset_occ", occ, 0);
    check("reset_l2_res", bus.l2_res, 0);
    check("reset_mem_req", bus.mem_req, 0);
    rst = 1'b0;
    tick();

    // Single write, then drain held until memory answers.
    d1 = {32{4'h1}};
    l2_xact(32'h0000_1000, d1, 1'b1, rd, lat);
    check("w1_latency", lat, 1);
    check("w1_occ", occ, 1);
    wait_mem_valid("w1_drain_valid");
    repeat (3) tick();
    check("w1_drain_held", bus.mem_req, {32'h0000_1000, d1, 1'b1, 1'b1});
    mem_stall = 1'b0;
    wait_occ_zero("w1_occ_after_drain");
    check("w1_log_size", mem_log.size(), 1);
    if (mem_log.size() >= 1) check("w1_log_entry", {mem_log[0].addr, mem_log[0].data, mem_log[0].rw},
                                   {32'h0000_1000, d1, 1'b1});
    mem_log.delete();

    // Fill the buffer with memory stalled.
    mem_stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      l2_xact(vecs[i].addr, vecs[i].data, vecs[i].rw, rd, lat);
      check($sformatf("fill_lat_%0d", i), lat, vecs[i].exp_lat);
      check($sformatf("fill_occ_%0d", i), occ, vecs[i].exp_occ);
    end

    // Fifth write waits on a full buffer until the first pop.
    d2 = {4{32'hC0DE_0004}};
    bus.l2_req = '{addr: 32'h0000_5040, data: d2, rw: 1'b1, valid: 1'b1};
    repeat (6) tick();
    check("full_ready_low", bus.l2_res.ready, 1'b0);
    check("full_occ", occ, 4);
    mem_stall = 1'b0;
    n = 0;
    while (!bus.l2_res.ready && n < 100) begin
      tick();
      n++;
    end
    check("full_ack_seen", bus.l2_res.ready, 1'b1);
    check("full_ack_after_pop", mem_log.size() >= 1, 1'b1);
    check("full_occ_at_ack", occ, 4);
    bus.l2_req = '0;
    tick();
    wait_occ_zero("fill_drained");
    check("fill_log_size", mem_log.size(), 5);
    for (int i = 0; i < 5 && i < mem_log.size(); i++) begin
      check($sformatf("fill_order_%0d", i), {mem_log[i].addr, mem_log[i].data, mem_log[i].rw},
            {32'h0000_5000 + 32'(i * 16), (i < 4) ? vecs[i % 4].data : d2, 1'b1});
    end
    mem_log.delete();

`ifdef WB_FWD_EN
    // Read forwarding from a buffered line.
    mem_stall = 1'b1;
    d1 = {4{32'hF00D_2000}};
    l2_xact(32'h0000_2000, d1, 1'b1, rd, lat);
    l2_xact(32'h0000_2004, '0, 1'b0, rd, lat);
    check("fwd_lat", lat, 1);
    check("fwd_data", rd, d1);
    mem_stall = 1'b0;
    wait_occ_zero("fwd_drained");
    n = 0;
    foreach (mem_log[i]) if (!mem_log[i].rw) n++;
    check("fwd_no_mem_read", n, 0);
    mem_log.delete();

    // Write merge into an existing entry.
    mem_stall = 1'b1;
    d1 = {4{32'h3333_0001}};
    d2 = {4{32'h3333_0002}};
    l2_xact(32'h0000_3000, d1, 1'b1, rd, lat);
    l2_xact(32'h0000_3000, d2, 1'b1, rd, lat);
    check("merge_occ", occ, 1);
    mem_stall = 1'b0;
    wait_occ_zero("merge_drained");
    check("merge_log_size", mem_log.size(), 1);
    if (mem_log.size() >= 1) check("merge_data", mem_log[0].data, d2);
    mem_log.delete();
`else
    // Without forwarding a read waits for every buffered write to drain.
    mem_stall = 1'b1;
    l2_xact(32'h0000_4010, {4{32'h4444_0010}}, 1'b1, rd, lat);
    l2_xact(32'h0000_4020, {4{32'h4444_0020}}, 1'b1, rd, lat);
    check("nofwd_occ", occ, 2);
    mem_stall = 1'b0;
    l2_xact(32'h0000_4000, '0, 1'b0, rd, lat);
    check("nofwd_read_data", rd, def_data(28'h000_0400));
    check("nofwd_log_size", mem_log.size(), 3);
    if (mem_log.size() == 3) begin
      check("nofwd_order_w0", {mem_log[0].rw, mem_log[0].addr}, {1'b1, 32'h0000_4010});
      check("nofwd_order_w1", {mem_log[1].rw, mem_log[1].addr}, {1'b1, 32'h0000_4020});
      check("nofwd_order_rd", {mem_log[2].rw, mem_log[2].addr}, {1'b0, 32'h0000_4000});
    end
    mem_log.delete();
`endif

    // Reset in the middle of a drain.
    mem_stall = 1'b1;
    l2_xact(32'h0000_6000, {4{32'h6666_6000}}, 1'b1, rd, lat);
    wait_mem_valid("rst_drain_started");
    rst = 1'b1;
    tick();
    check("rst_mid_occ", occ, 0);
    check("rst_mid_mem_valid", bus.mem_req.valid, 1'b0);
    check("rst_mid_l2_ready", bus.l2_res.ready, 1'b0);
    rst = 1'b0;
    tick();
    mem_stall = 1'b0;
    l2_xact(32'h0000_6010, {4{32'h6666_6010}}, 1'b1, rd, lat);
    check("rst_after_lat", lat, 1);
    wait_occ_zero("rst_after_drained");
    check("rst_after_log_size", mem_log.size(), 1);
    if (mem_log.size() >= 1) check("rst_after_log_addr", mem_log[0].addr, 32'h0000_6010);
    mem_log.delete();

    // Randomized traffic over a small line pool with random memory latency.
    lat_max = 3;
    for (int i = 0; i < 300; i++) begin
      logic [27:0]  line;
      logic [31:0]  addr;
      logic [127:0] data;
      bit           rw;
      line = 28'h000_0900 + 28'($urandom_range(0, 7));
      addr = {line, 4'($urandom)};
      rw   = 1'($urandom);
      data = {$urandom, $urandom, $urandom, $urandom};
      l2_xact(addr, data, rw, rd, lat);
      if (rw) ref_mem[line] = data;
      else check("rand_read", rd, ref_mem.exists(line) ? ref_mem[line] : def_data(line));
      check("rand_occ_bound", occ <= DEPTH, 1'b1);
    end
    wait_occ_zero("rand_drained");
    foreach (ref_mem[l]) check("rand_mem_final", mem_store.exists(l) ? mem_store[l] : def_data(l), ref_mem[l]);
    n = 0;
    foreach (mem_log[i]) if (mem_log[i].addr[3:0] != 4'h0) n++;
    check("rand_addr_aligned", n, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
